// File: rtl/approx_err_monitor_if.sv
// Sample/control bundle between the approximate-arithmetic partition and approx_err_monitor.
// A sample transfers on a rising clk edge where in_valid && in_ready; in_ready depends only on monitor state, never on in_valid.
interface approx_err_monitor_if #(
  parameter int OUT_W = 6,
  parameter int CNT_W = 16
);
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] exact;
  logic [OUT_W-1:0] approx;

  modport master (output start, num_samples, in_valid, exact, approx, input in_ready);
  modport slave  (input start, num_samples, in_valid, exact, approx, output in_ready);
endinterface

// File: rtl/approx_err_monitor.sv
// Windowed Hamming-distance error monitor for exact vs approximate output vectors.
// Optional absolute-error accumulation is enabled by defining APPROX_ERR_MONITOR_ABS_ERR_EN.
module approx_err_monitor #(
  parameter int OUT_W = 6,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24,
  parameter int HD_W  = $clog2(OUT_W + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  approx_err_monitor_if.slave  bus,
  output logic                 busy,
  output logic                 done,
  output logic [ACC_W-1:0]     hd_sum,
  output logic [CNT_W-1:0]     err_count,
  output logic [HD_W-1:0]      max_hd,
  output logic [CNT_W-1:0]     sample_count,
  output logic [1:0]           state
`ifdef APPROX_ERR_MONITOR_ABS_ERR_EN
  ,
  output logic [ACC_W:0]       aed_sum,
  output logic [OUT_W-1:0]     max_aed
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [CNT_W-1:0] n_lat;
  logic             s1_valid;
  logic             s2_valid;
  logic [OUT_W-1:0] s1_diff;
  logic [HD_W-1:0]  s1_pop;
  logic [HD_W-1:0]  s2_hd;
  logic             accept;
  logic             start_ok;
  logic [ACC_W:0]   hd_sum_wide;

  assign bus.in_ready = (state == RUN) && (sample_count < n_lat);
  assign accept       = bus.in_valid && bus.in_ready;
  assign start_ok     = bus.start && ((state == IDLE) || (state == DONE));
  assign busy         = (state == RUN) || (state == DRAIN);
  assign done         = (state == DONE);
  assign hd_sum_wide  = {1'b0, hd_sum} + (ACC_W+1)'(s2_hd);

  always_comb begin
    s1_pop = '0;
    for (int i = 0; i < OUT_W; i++) begin
      s1_pop = s1_pop + HD_W'(s1_diff[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      n_lat        <= '0;
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      s1_diff      <= '0;
      s2_hd        <= '0;
      hd_sum       <= '0;
      err_count    <= '0;
      max_hd       <= '0;
      sample_count <= '0;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (accept) s1_diff <= bus.exact ^ bus.approx;
      if (s1_valid) s2_hd <= s1_pop;

      // Pipeline is always empty when a start is honoured, so clear never races an accumulate.
      if (start_ok) begin
        hd_sum       <= '0;
        err_count    <= '0;
        max_hd       <= '0;
        sample_count <= '0;
      end else begin
        if (accept) sample_count <= sample_count + CNT_W'(1);
        if (s2_valid) begin
          hd_sum <= hd_sum_wide[ACC_W] ? {ACC_W{1'b1}} : hd_sum_wide[ACC_W-1:0];
          if (s2_hd != '0) err_count <= err_count + CNT_W'(1);
          if (s2_hd > max_hd) max_hd <= s2_hd;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            n_lat <= bus.num_samples;
            state <= (bus.num_samples == '0) ? DRAIN : RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (accept && (sample_count + CNT_W'(1) == n_lat)) state <= DRAIN;
        end
        DRAIN: begin
          if (!s1_valid && !s2_valid) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef APPROX_ERR_MONITOR_ABS_ERR_EN
  logic [OUT_W-1:0] s1_aed;
  logic [OUT_W-1:0] s2_aed;
  logic [ACC_W+1:0] aed_sum_wide;

  assign aed_sum_wide = {1'b0, aed_sum} + (ACC_W+2)'(s2_aed);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_aed  <= '0;
      s2_aed  <= '0;
      aed_sum <= '0;
      max_aed <= '0;
    end else begin
      if (accept) begin
        s1_aed <= (bus.exact >= bus.approx) ? (bus.exact - bus.approx) : (bus.approx - bus.exact);
      end
      if (s1_valid) s2_aed <= s1_aed;
      if (start_ok) begin
        aed_sum <= '0;
        max_aed <= '0;
      end else if (s2_valid) begin
        aed_sum <= aed_sum_wide[ACC_W+1] ? {(ACC_W+1){1'b1}} : aed_sum_wide[ACC_W:0];
        if (s2_aed > max_aed) max_aed <= s2_aed;
      end
    end
  end
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed self-checking bench for approx_err_monitor (main instance plus a narrow-accumulator instance).
module tb_approx_err_monitor;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   accepts;
  logic [5:0] exp_q[$];

  approx_err_monitor_if #(.OUT_W(6), .CNT_W(16)) bus ();
  approx_err_monitor_if #(.OUT_W(6), .CNT_W(16)) sbus ();

  logic        busy, done;
  logic [23:0] hd_sum;
  logic [15:0] err_count, sample_count;
  logic [2:0]  max_hd;
  logic [1:0]  state;

  logic        s_busy, s_done;
  logic [3:0]  s_hd_sum;
  logic [15:0] s_err_count, s_sample_count;
  logic [2:0]  s_max_hd;
  logic [1:0]  s_state;

`ifdef APPROX_ERR_MONITOR_ABS_ERR_EN
  logic [24:0] aed_sum;
  logic [5:0]  max_aed;
  logic [4:0]  s_aed_sum;
  logic [5:0]  s_max_aed;
`endif

  approx_err_monitor #(.OUT_W(6), .CNT_W(16), .ACC_W(24)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy(busy), .done(done), .hd_sum(hd_sum), .err_count(err_count),
    .max_hd(max_hd), .sample_count(sample_count), .state(state)
`ifdef APPROX_ERR_MONITOR_ABS_ERR_EN
    , .aed_sum(aed_sum), .max_aed(max_aed)
`endif
  );

  approx_err_monitor #(.OUT_W(6), .CNT_W(16), .ACC_W(4)) dut_sat (
    .clk(clk), .rst(rst), .bus(sbus),
    .busy(s_busy), .done(s_done), .hd_sum(s_hd_sum), .err_count(s_err_count),
    .max_hd(s_max_hd), .sample_count(s_sample_count), .state(s_state)
`ifdef APPROX_ERR_MONITOR_ABS_ERR_EN
    , .aed_sum(s_aed_sum), .max_aed(s_max_aed)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: every task starts and ends at a falling edge.
  task automatic start_window(input logic [15:0] n);
    bus.start = 1'b1;
    bus.num_samples = n;
    @(negedge clk);
    bus.start = 1'b0;
    accepts = 0;
    exp_q.delete();
  endtask

  task automatic drive_sample(input logic [5:0] e, input logic [5:0] a, input logic v);
    bus.in_valid = v;
    bus.exact = e;
    bus.approx = a;
    if (v && bus.in_ready === 1'b1) begin
      accepts++;
      exp_q.push_back(e ^ a);
    end
    @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output int lat, output int pulses);
    bus.in_valid = 1'b0;
    lat = 0;
    pulses = 0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        pulses++;
        if (lat == 0) lat = i + 1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int pulses;
    pulses = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1) pulses++;
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
      @(negedge clk);
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL reset_done_pulses got=%0d exp=0", pulses); end
    checks++; if (hd_sum !== 24'd0) begin failures++; $display("FAIL reset_hd_sum got=%0d exp=0", hd_sum); end
    checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    checks++; if (max_hd !== 3'd0) begin failures++; $display("FAIL reset_max_hd got=%0d exp=0", max_hd); end
    checks++; if (sample_count !== 16'd0) begin failures++; $display("FAIL reset_sample_count got=%0d exp=0", sample_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
`ifdef APPROX_ERR_MONITOR_ABS_ERR_EN
    checks++; if (aed_sum !== 25'd0 || max_aed !== 6'd0) begin failures++; $display("FAIL reset_aed got=%0d/%0d exp=0/0", aed_sum, max_aed); end
`endif
  endtask

  task automatic test_exact_match();
    int lat, pulses;
    start_window(16'd8);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL match_busy got=%b exp=1", busy); end
    for (int i = 0; i < 8; i++) drive_sample(6'h2A, 6'h2A, 1'b1);
    checks++; if (accepts != 8) begin failures++; $display("FAIL match_back_to_back_accepts got=%0d exp=8", accepts); end
    wait_done(8, lat, pulses);
    checks++; if (pulses != 1) begin failures++; $display("FAIL match_done_pulses got=%0d exp=1", pulses); end
    checks++; if (lat < 1 || lat > 4) begin failures++; $display("FAIL match_done_latency got=%0d exp=1..4", lat); end
    checks++; if (hd_sum !== 24'd0 || err_count !== 16'd0 || max_hd !== 3'd0) begin failures++; $display("FAIL match_results got=%0d/%0d/%0d exp=0/0/0", hd_sum, err_count, max_hd); end
    checks++; if (sample_count !== 16'd8) begin failures++; $display("FAIL match_sample_count got=%0d exp=8", sample_count); end
  endtask

  task automatic test_mixed_errors();
    int lat, pulses;
    start_window(16'd4);
    drive_sample(6'h00, 6'h3F, 1'b1);
    drive_sample(6'h15, 6'h14, 1'b1);
    drive_sample(6'h07, 6'h07, 1'b1);
    drive_sample(6'h20, 6'h00, 1'b1);
    wait_done(8, lat, pulses);
    checks++; if (exp_q.size() != 4) begin failures++; $display("FAIL mixed_accepts got=%0d exp=4", exp_q.size()); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL mixed_done_pulses got=%0d exp=1", pulses); end
    checks++; if (hd_sum !== 24'd8) begin failures++; $display("FAIL mixed_hd_sum got=%0d exp=8", hd_sum); end
    checks++; if (err_count !== 16'd3) begin failures++; $display("FAIL mixed_err_count got=%0d exp=3", err_count); end
    checks++; if (max_hd !== 3'd6) begin failures++; $display("FAIL mixed_max_hd got=%0d exp=6", max_hd); end
    checks++; if (state !== 2'd0 || busy !== 1'b0) begin failures++; $display("FAIL mixed_idle_after got=%0d/%b exp=0/0", state, busy); end
`ifdef APPROX_ERR_MONITOR_ABS_ERR_EN
    checks++; if (aed_sum !== 25'd96) begin failures++; $display("FAIL mixed_aed_sum got=%0d exp=96", aed_sum); end
    checks++; if (max_aed !== 6'd63) begin failures++; $display("FAIL mixed_max_aed got=%0d exp=63", max_aed); end
`endif
  endtask

  task automatic test_gapped_valid();
    int lat, pulses;
    start_window(16'd3);
    drive_sample(6'h01, 6'h00, 1'b1);
    drive_sample(6'h3F, 6'h00, 1'b0);
    drive_sample(6'h3F, 6'h00, 1'b0);
    drive_sample(6'h03, 6'h00, 1'b1);
    drive_sample(6'h3F, 6'h00, 1'b0);
    drive_sample(6'h07, 6'h00, 1'b1);
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL gapped_ready_drop got=%b exp=0", bus.in_ready); end
    drive_sample(6'h3F, 6'h00, 1'b1);
    wait_done(8, lat, pulses);
    checks++; if (accepts != 3) begin failures++; $display("FAIL gapped_accepts got=%0d exp=3", accepts); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL gapped_done_pulses got=%0d exp=1", pulses); end
    checks++; if (sample_count !== 16'd3) begin failures++; $display("FAIL gapped_sample_count got=%0d exp=3", sample_count); end
    checks++; if (hd_sum !== 24'd6 || err_count !== 16'd3 || max_hd !== 3'd3) begin failures++; $display("FAIL gapped_results got=%0d/%0d/%0d exp=6/3/3", hd_sum, err_count, max_hd); end
  endtask

  task automatic test_zero_and_start_ignore();
    int lat, pulses;
    start_window(16'd0);
    wait_done(6, lat, pulses);
    checks++; if (lat != 2 || pulses != 1) begin failures++; $display("FAIL zero_done got lat=%0d pulses=%0d exp lat=2 pulses=1", lat, pulses); end
    checks++; if (hd_sum !== 24'd0 || err_count !== 16'd0 || max_hd !== 3'd0 || sample_count !== 16'd0) begin
      failures++; $display("FAIL zero_results got=%0d/%0d/%0d/%0d exp=0/0/0/0", hd_sum, err_count, max_hd, sample_count);
    end
    start_window(16'd5);
    drive_sample(6'h00, 6'h01, 1'b1);
    drive_sample(6'h00, 6'h01, 1'b1);
    bus.start = 1'b1;
    bus.num_samples = 16'd1;
    drive_sample(6'h00, 6'h01, 1'b1);
    bus.start = 1'b0;
    bus.num_samples = 16'd5;
    drive_sample(6'h00, 6'h01, 1'b1);
    drive_sample(6'h00, 6'h01, 1'b1);
    wait_done(8, lat, pulses);
    checks++; if (pulses != 1) begin failures++; $display("FAIL ignore_done_pulses got=%0d exp=1", pulses); end
    checks++; if (sample_count !== 16'd5) begin failures++; $display("FAIL ignore_sample_count got=%0d exp=5", sample_count); end
    checks++; if (hd_sum !== 24'd5 || err_count !== 16'd5 || max_hd !== 3'd1) begin failures++; $display("FAIL ignore_results got=%0d/%0d/%0d exp=5/5/1", hd_sum, err_count, max_hd); end
  endtask

  task automatic test_saturation();
    sbus.start = 1'b1;
    sbus.num_samples = 16'd3;
    @(negedge clk);
    sbus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sbus.in_valid = 1'b1;
      sbus.exact = 6'h3F;
      sbus.approx = 6'h00;
      @(negedge clk);
    end
    sbus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (s_hd_sum !== 4'd15) begin failures++; $display("FAIL sat_hd_sum got=%0d exp=15", s_hd_sum); end
    checks++; if (s_err_count !== 16'd3 || s_max_hd !== 3'd6 || s_sample_count !== 16'd3) begin
      failures++; $display("FAIL sat_counts got=%0d/%0d/%0d exp=3/6/3", s_err_count, s_max_hd, s_sample_count);
    end
`ifdef APPROX_ERR_MONITOR_ABS_ERR_EN
    checks++; if (s_aed_sum !== 5'd31 || s_max_aed !== 6'd63) begin failures++; $display("FAIL sat_aed got=%0d/%0d exp=31/63", s_aed_sum, s_max_aed); end
`endif
  endtask

  task automatic test_abort();
    int lat, pulses;
    start_window(16'd5);
    drive_sample(6'h3F, 6'h00, 1'b1);
    drive_sample(6'h3F, 6'h00, 1'b1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (state !== 2'd0 || busy !== 1'b0 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
      failures++; $display("FAIL abort_ctrl got state=%0d busy=%b done=%b ready=%b exp 0/0/0/0", state, busy, done, bus.in_ready);
    end
    checks++; if (hd_sum !== 24'd0 || err_count !== 16'd0 || max_hd !== 3'd0 || sample_count !== 16'd0) begin
      failures++; $display("FAIL abort_results got=%0d/%0d/%0d/%0d exp=0/0/0/0", hd_sum, err_count, max_hd, sample_count);
    end
    rst = 1'b0;
    wait_done(6, lat, pulses);
    checks++; if (pulses != 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", pulses); end
    checks++; if (hd_sum !== 24'd0 || err_count !== 16'd0) begin failures++; $display("FAIL abort_inflight_discarded got=%0d/%0d exp=0/0", hd_sum, err_count); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    accepts = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.num_samples = '0; bus.in_valid = 1'b0; bus.exact = '0; bus.approx = '0;
    sbus.start = 1'b0; sbus.num_samples = '0; sbus.in_valid = 1'b0; sbus.exact = '0; sbus.approx = '0;
    test_reset();
    test_exact_match();
    test_mixed_errors();
    test_gapped_valid();
    test_zero_and_start_ignore();
    test_saturation();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
